// File: rtl/slicer_err_win.sv
// Decision-directed 4-ASK slicer with windowed mean-|x| reference tracking.
// Latency: err/dec/sym_idx registered 1 clk after the sampling clk_en edge.
// No backpressure: consumes one symbol per clk_en pulse, gaps of any length allowed.
module slicer_err_win #(
  parameter int                 WIN_LEN  = 10,
  parameter logic signed [17:0] REF_INIT = 18'sd65536,
  parameter logic signed [17:0] REF_MAX  = 18'sd87380
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic signed [17:0]        sym_in,
  output logic signed [17:0]        err,
  output logic signed [17:0]        dec,
  output logic [1:0]                sym_idx,
  output logic signed [17:0]        ref_lvl,
  output logic                      hold,
  output logic [WIN_LEN-1:0]        win_cnt
);

  localparam int ACC_W = 18 + WIN_LEN;

  // Abs accumulator for the current window; wide enough for 2^WIN_LEN full-scale symbols.
  logic [ACC_W-1:0]   acc;
  // Set once hold has survived the first clk_en after the boundary; clears hold next edge.
  logic               hold_seen;

  logic signed [18:0] sym19;
  logic signed [18:0] b19;
  logic signed [18:0] h19;
  logic signed [18:0] o19;
  logic signed [18:0] dec_n;
  logic signed [18:0] err_n;
  logic [1:0]         idx_n;
  logic [17:0]        sym_abs;
  logic [ACC_W-1:0]   acc_sum;
  logic [17:0]        mean;
  logic signed [17:0] ref_n;
  logic               terminal;

  assign sym19    = {sym_in[17], sym_in};
  assign b19      = {ref_lvl[17], ref_lvl};
  assign h19      = b19 >>> 1;
  assign o19      = b19 + h19;
  assign terminal = (win_cnt == {WIN_LEN{1'b1}});

  // Four-region slicer against the current reference; ties go to the upper region.
  always_comb begin
    dec_n = '0;
    idx_n = 2'd0;
    if (sym19 >= b19) begin
      dec_n = o19;
      idx_n = 2'd3;
    end else if (sym19 >= 19'sd0) begin
      dec_n = h19;
      idx_n = 2'd2;
    end else if (sym19 >= -b19) begin
      dec_n = -h19;
      idx_n = 2'd1;
    end else begin
      dec_n = -o19;
      idx_n = 2'd0;
    end
  end

  // The REF_MAX clamp keeps |sym - dec| inside 18 bits, so truncation below is lossless.
  assign err_n = sym19 - dec_n;

  // Magnitude as unsigned 18 bits so that the most negative input maps to +2^17.
  assign sym_abs = sym_in[17] ? (~$unsigned(sym_in) + 18'd1) : $unsigned(sym_in);
  assign acc_sum = acc + ACC_W'(sym_abs);
  assign mean    = acc_sum[ACC_W-1:WIN_LEN];

  // Window mean clamped to [1, REF_MAX]; floor of 1 keeps the thresholds distinct.
  always_comb begin
    ref_n = REF_MAX;
    if (mean == 18'd0) begin
      ref_n = 18'sd1;
    end else if (mean <= $unsigned(REF_MAX)) begin
      ref_n = $signed(mean);
    end
  end

  // Register slicer outputs on each symbol; they hold between clk_en pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err     <= '0;
      dec     <= '0;
      sym_idx <= 2'd0;
    end else if (clk_en) begin
      err     <= err_n[17:0];
      dec     <= dec_n[17:0];
      sym_idx <= idx_n;
    end
  end

  // Window counting, accumulation and reference update at the terminal symbol.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      win_cnt <= '0;
      ref_lvl <= REF_INIT;
    end else if (clk_en) begin
      win_cnt <= win_cnt + WIN_LEN'(1);
      if (terminal) begin
        acc     <= '0;
        ref_lvl <= ref_n;
      end else begin
        acc     <= acc_sum;
      end
    end
  end

  // hold rises at the boundary, spans the next clk_en edge, and drops on the edge after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold      <= 1'b0;
      hold_seen <= 1'b0;
    end else if (clk_en && terminal) begin
      hold      <= 1'b1;
      hold_seen <= 1'b0;
    end else if (hold_seen) begin
      hold      <= 1'b0;
      hold_seen <= 1'b0;
    end else if (clk_en && hold) begin
      hold_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_slicer_err_win.sv
// Self-checking bench for slicer_err_win with a 16-symbol window.
// Expected slicer outputs come from a table or a reference model, queued at drive time.
// Outputs are sampled on the falling edge, away from the active rising edge.
module tb_slicer_err_win;

  localparam int WL = 4;
  localparam int WN = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               clk_en = 1'b0;
  logic signed [17:0] sym_in = '0;
  logic signed [17:0] err;
  logic signed [17:0] dec;
  logic [1:0]         sym_idx;
  logic signed [17:0] ref_lvl;
  logic               hold;
  logic [WL-1:0]      win_cnt;

  slicer_err_win #(.WIN_LEN(WL)) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .sym_in  (sym_in),
    .err     (err),
    .dec     (dec),
    .sym_idx (sym_idx),
    .ref_lvl (ref_lvl),
    .hold    (hold),
    .win_cnt (win_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sym;
    int dec;
    int idx;
    int err;
  } vec_t;

  typedef struct {
    int dec;
    int idx;
    int err;
    int ref_v;
    int cnt;
    int hold;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ref;
  int m_acc;
  int m_cnt;
  int m_hold;
  int m_seen;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_ref  = 65536;
    m_acc  = 0;
    m_cnt  = 0;
    m_hold = 0;
    m_seen = 0;
  endtask

  task automatic slice(input int s, input int b, output int d, output int i, output int e);
    int h;
    int o;
    h = b / 2;
    o = b + h;
    if (s >= b) begin
      d = o;  i = 3;
    end else if (s >= 0) begin
      d = h;  i = 2;
    end else if (s >= -b) begin
      d = -h; i = 1;
    end else begin
      d = -o; i = 0;
    end
    e = s - d;
  endtask

  // Asynchronous reset mid-stream: outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    clk_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_err",  int'(err), 0);
    chk("rst_dec",  int'(dec), 0);
    chk("rst_idx",  int'(sym_idx), 0);
    chk("rst_hold", int'(hold), 0);
    chk("rst_cnt",  int'(win_cnt), 0);
    chk("rst_ref",  int'(ref_lvl), 65536);
    model_reset();
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive one symbol (called at a falling edge); tbl_use selects table-given slice expectations.
  task automatic send(input int s, input bit tbl_use, input int tdec, input int tidx, input int terr);
    exp_t x;
    int d, i, e, a, mean;
    bit term;
    sym_in = 18'(s);
    clk_en = 1'b1;
    slice(s, m_ref, d, i, e);
    if (e < -131072 || e > 131071) begin
      checks++;
      errors++;
      $display("FAIL err_range: model err %0d exceeds 18 bits", e);
    end
    a    = (s < 0) ? -s : s;
    term = (m_cnt == WN - 1);
    m_acc += a;
    if (term) begin
      mean = m_acc / WN;
      if (mean < 1) mean = 1;
      if (mean > 87380) mean = 87380;
      m_ref = mean;
      m_acc = 0;
      m_cnt = 0;
      m_hold = 1;
      m_seen = 0;
    end else begin
      m_cnt++;
      if (m_seen != 0) begin
        m_hold = 0;
        m_seen = 0;
      end else if (m_hold != 0) begin
        m_seen = 1;
      end
    end
    x.dec   = tbl_use ? tdec : d;
    x.idx   = tbl_use ? tidx : i;
    x.err   = tbl_use ? terr : e;
    x.ref_v = m_ref;
    x.cnt   = m_cnt;
    x.hold  = m_hold;
    sb.push_back(x);
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got no expectation, required one");
    end else begin
      x = sb.pop_front();
      chk("dec",  int'(dec), x.dec);
      chk("idx",  int'(sym_idx), x.idx);
      chk("err",  int'(err), x.err);
      chk("ref",  int'(ref_lvl), x.ref_v);
      chk("cnt",  int'(win_cnt), x.cnt);
      chk("hold", int'(hold), x.hold);
    end
  endtask

  task automatic sym(input int s);
    send(s, 1'b0, 0, 0, 0);
  endtask

  // Clock edges with clk_en low: outputs hold, hold flag may retire.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (m_seen != 0) begin
        m_hold = 0;
        m_seen = 0;
      end
      @(negedge clk);
      chk("idle_hold", int'(hold), m_hold);
      chk("idle_cnt",  int'(win_cnt), m_cnt);
      chk("idle_ref",  int'(ref_lvl), m_ref);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{40000,    32768, 2,   7232};
    tbl[1] = '{-70000,  -98304, 0,  28304};
    tbl[2] = '{65536,    98304, 3, -32768};
    tbl[3] = '{-65536,  -32768, 1, -32768};
    tbl[4] = '{0,        32768, 2, -32768};
    tbl[5] = '{-1,      -32768, 1,  32767};
    tbl[6] = '{65535,    32768, 2,  32767};
    tbl[7] = '{131071,   98304, 3,  32767};
    tbl[8] = '{-131072, -98304, 0, -32768};
    tbl[9] = '{-65537,  -98304, 0,  32767};

    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // Some activity so the reset really happens mid-stream
    sym(100000);
    sym(-5000);
    do_reset();

    // Table of slices at b = 65536
    for (int k = 0; k < 10; k++) begin
      send(tbl[k].sym, 1'b1, tbl[k].dec, tbl[k].idx, tbl[k].err);
      if (k == 0) chk("first_cnt", int'(win_cnt), 1);
      if ((k % 3) == 1) idle(k % 4);
    end

    // Window update with gaps between symbols
    do_reset();
    for (int k = 0; k < WN; k++) begin
      sym((k % 2 == 0) ? 49152 : -49152);
      if (k < WN - 1) begin
        chk("win_hold_low", int'(hold), 0);
        idle($urandom_range(0, 2));
      end
    end
    chk("win_ref",  int'(ref_lvl), 49152);
    chk("win_cnt0", int'(win_cnt), 0);
    chk("win_hold", int'(hold), 1);
    idle(2);
    send(30000, 1'b1, 24576, 2, 5424);
    chk("hold_17th", int'(hold), 1);
    idle(1);
    chk("hold_clr", int'(hold), 0);

    // Clamp to REF_MAX, then floor to 1
    do_reset();
    for (int k = 0; k < WN; k++) sym(131071);
    chk("clamp_max", int'(ref_lvl), 87380);
    for (int k = 0; k < WN; k++) sym(0);
    chk("clamp_min", int'(ref_lvl), 1);
    for (int k = 0; k < WN; k++) sym(-131072);
    chk("clamp_neg", int'(ref_lvl), 87380);
    sym(-131072);
    sym(131071);
    idle(2);

    // Reset mid-window discards the partial accumulation
    do_reset();
    for (int k = 0; k < 7; k++) sym(100000);
    do_reset();
    for (int k = 0; k < WN; k++) begin
      sym((k % 2 == 0) ? 20000 : -20000);
      if (k < WN - 1) chk("mw_hold_low", int'(hold), 0);
    end
    chk("mw_ref",  int'(ref_lvl), 20000);
    chk("mw_hold", int'(hold), 1);
    sym(10000);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
